// File: rtl/pipeline_controller.sv
// Hazard, redirect and freeze control for a 5-stage in-order pipeline.
// Ports: stage write/flush enables, PC redirect, stall and flush counters.
module pipeline_controller #(
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  mem_hazard,
   input  logic                  mispredict,
   input  logic [DATA_WIDTH-1:0] target_ex,
   input  logic                  icache_valid,
   input  logic                  dcache_busy,
   input  logic                  ecall_wb,
   input  logic                  ecall_done,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  id_ex_write,
   output logic                  ex_mem_write,
   output logic                  mem_wb_write,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  redirect_valid,
   output logic [DATA_WIDTH-1:0] redirect_pc,
   output logic [CNT_WIDTH-1:0]  stall_cycles,
   output logic [CNT_WIDTH-1:0]  flush_count
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      MEM_WAIT   = 2'd1,
      ECALL_WAIT = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic                  pend_valid;
   logic [DATA_WIDTH-1:0] pend_pc;
   logic                  frozen;
   logic                  redir;
   logic [DATA_WIDTH-1:0] redir_tgt;

   assign frozen = (state == MEM_WAIT) || (state == ECALL_WAIT) ||
                   dcache_busy || ((state == RUN) && ecall_wb);
   assign redir     = mispredict || pend_valid;
   assign redir_tgt = mispredict ? target_ex : pend_pc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= RUN;
         pend_valid <= 1'b0;
         pend_pc    <= '0;
      end else begin
         state <= state_nxt;
         // a redirect that cannot issue now is held until the freeze ends
         if (frozen && mispredict) begin
            pend_valid <= 1'b1;
            pend_pc    <= target_ex;
         end else if (!frozen && redir) begin
            pend_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (!pc_write && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
         if (redirect_valid && (flush_count != '1))
            flush_count <= flush_count + 1'b1;
      end
   end

   always_comb begin
      state_nxt      = state;
      pc_write       = 1'b0;
      if_id_write    = 1'b0;
      id_ex_write    = 1'b0;
      ex_mem_write   = 1'b0;
      mem_wb_write   = 1'b0;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      unique case (state)
         RUN: begin
            // an ecall behind a busy dcache waits until the access drains
            if (dcache_busy && !ecall_wb)
               state_nxt = MEM_WAIT;
            else if (ecall_wb && !dcache_busy)
               state_nxt = ECALL_WAIT;
         end
         MEM_WAIT: begin
            if (!dcache_busy)
               state_nxt = RUN;
         end
         ECALL_WAIT: begin
            if (ecall_done)
               state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase

      if (reset_n && !frozen) begin
         ex_mem_write = 1'b1;
         mem_wb_write = 1'b1;
         id_ex_write  = 1'b1;
         if (redir) begin
            pc_write       = 1'b1;
            if_id_write    = 1'b1;
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = redir_tgt;
         end else if (mem_hazard) begin
            id_ex_flush = 1'b1;
         end else if (!icache_valid) begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
         end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed scenarios
// followed by random traffic against a rule-level reference model.
module tb_pipeline_controller;

   localparam int DW = 64;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          mem_hazard, mispredict, icache_valid;
   logic          dcache_busy, ecall_wb, ecall_done;
   logic [DW-1:0] target_ex;
   logic          pc_write, if_id_write, id_ex_write;
   logic          ex_mem_write, mem_wb_write;
   logic          if_id_flush, id_ex_flush, redirect_valid;
   logic [DW-1:0] redirect_pc;
   logic [CW-1:0] stall_cycles, flush_count;

   int total = 0;
   int bad   = 0;

   // model: 0 = running, 1 = waiting on dcache, 2 = waiting on host
   int            m_mode;
   bit            m_pv;
   logic [DW-1:0] m_ppc;
   int            m_stall, m_flush;

   pipeline_controller #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset_n(reset_n),
      .mem_hazard(mem_hazard), .mispredict(mispredict),
      .target_ex(target_ex), .icache_valid(icache_valid),
      .dcache_busy(dcache_busy), .ecall_wb(ecall_wb),
      .ecall_done(ecall_done),
      .pc_write(pc_write), .if_id_write(if_id_write),
      .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
      .mem_wb_write(mem_wb_write),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode  = 0;
      m_pv    = 0;
      m_ppc   = '0;
      m_stall = 0;
      m_flush = 0;
   endtask

   // one clock: apply inputs, check outputs mid-cycle, advance model
   task automatic cycle(input bit hz, input bit mp, input logic [DW-1:0] tg,
                        input bit iv, input bit db, input bit ew,
                        input bit ed);
      bit frz, rd, idw_care;
      logic [DW-1:0] tpc;
      bit e_pc, e_ifw, e_idw, e_exw, e_mww, e_iff, e_idf, e_rv;
      mem_hazard   = hz;
      mispredict   = mp;
      target_ex    = tg;
      icache_valid = iv;
      dcache_busy  = db;
      ecall_wb     = ew;
      ecall_done   = ed;
      frz = (m_mode != 0) || db || (m_mode == 0 && ew);
      rd  = mp || m_pv;
      tpc = mp ? tg : m_ppc;
      idw_care = 1;
      {e_pc, e_ifw, e_idw, e_exw, e_mww, e_iff, e_idf, e_rv} = '0;
      if (frz) begin
      end else if (rd) begin
         {e_pc, e_ifw, e_idw, e_exw, e_mww} = '1;
         {e_iff, e_idf, e_rv} = '1;
      end else if (hz) begin
         {e_exw, e_mww, e_idf} = '1;
         idw_care = 0;
      end else if (!iv) begin
         {e_ifw, e_idw, e_exw, e_mww, e_iff} = '1;
      end else begin
         {e_pc, e_ifw, e_idw, e_exw, e_mww} = '1;
      end
      @(negedge clk);
      chk("pc_write", DW'(pc_write), DW'(e_pc));
      chk("if_id_write", DW'(if_id_write), DW'(e_ifw));
      if (idw_care) chk("id_ex_write", DW'(id_ex_write), DW'(e_idw));
      chk("ex_mem_write", DW'(ex_mem_write), DW'(e_exw));
      chk("mem_wb_write", DW'(mem_wb_write), DW'(e_mww));
      chk("if_id_flush", DW'(if_id_flush), DW'(e_iff));
      chk("id_ex_flush", DW'(id_ex_flush), DW'(e_idf));
      chk("redirect_valid", DW'(redirect_valid), DW'(e_rv));
      if (e_rv) chk("redirect_pc", redirect_pc, tpc);
      chk("stall_cycles", DW'(stall_cycles), DW'(m_stall));
      chk("flush_count", DW'(flush_count), DW'(m_flush));
      if (!e_pc && m_stall < CMAX) m_stall++;
      if (e_rv && m_flush < CMAX) m_flush++;
      if (frz && mp) begin
         m_pv  = 1;
         m_ppc = tg;
      end else if (!frz && rd) begin
         m_pv = 0;
      end
      case (m_mode)
         0: if (db && !ew) m_mode = 1;
            else if (ew && !db) m_mode = 2;
         1: if (!db) m_mode = 0;
         default: if (ed) m_mode = 0;
      endcase
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, '0, 1, 0, 0, 0);
   endtask

   // asynchronous reset asserted mid-cycle, released after an edge
   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_writes", DW'({pc_write, if_id_write, id_ex_write,
                             ex_mem_write, mem_wb_write}), '0);
      chk("rst_flush", DW'({if_id_flush, id_ex_flush}), '0);
      chk("rst_redir_valid", DW'(redirect_valid), '0);
      chk("rst_redir_pc", redirect_pc, '0);
      chk("rst_stall", DW'(stall_cycles), '0);
      chk("rst_flushcnt", DW'(flush_count), '0);
      model_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      {mem_hazard, mispredict, dcache_busy, ecall_wb, ecall_done} = '0;
      icache_valid = 1'b1;
      target_ex    = '0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();
      idle(2);

      // load-use bubble then resume
      cycle(1, 0, '0, 1, 0, 0, 0);
      idle(1);
      // mispredict beats a load-use hazard
      cycle(1, 1, 64'h8000_1000, 1, 0, 0, 0);
      idle(1);
      // mispredict while dcache busy; redirect after the wait drains
      cycle(0, 1, 64'h400, 1, 1, 0, 0);
      cycle(0, 0, '0, 1, 1, 0, 0);
      cycle(0, 0, '0, 1, 1, 0, 0);
      cycle(0, 0, '0, 1, 0, 0, 0);
      idle(2);
      // two mispredicts while frozen: the later target wins
      cycle(0, 1, 64'h111, 1, 1, 0, 0);
      cycle(0, 1, 64'h222, 1, 1, 0, 0);
      cycle(0, 0, '0, 1, 0, 0, 0);
      idle(2);
      // ecall held until host pulses done
      do_reset();
      cycle(0, 0, '0, 1, 0, 1, 0);
      idle(4);
      cycle(0, 0, '0, 1, 0, 0, 1);
      chk("ecall_stall", DW'(stall_cycles), DW'(6));
      idle(2);
      // ecall_done while running is ignored
      cycle(0, 0, '0, 1, 0, 0, 1);
      // two-cycle fetch miss
      cycle(0, 0, '0, 0, 0, 0, 0);
      cycle(0, 0, '0, 0, 0, 0, 0);
      // hazard together with fetch miss
      cycle(1, 0, '0, 0, 0, 0, 0);
      idle(1);
      // reset during MEM_WAIT with a redirect pending
      cycle(0, 1, 64'hdead, 1, 1, 0, 0);
      cycle(0, 0, '0, 1, 1, 0, 0);
      do_reset();
      idle(3);
      // counter saturation
      for (int i = 0; i < 20; i++) cycle(1, 0, '0, 1, 0, 0, 0);
      for (int i = 0; i < 20; i++)
         cycle(0, 1, DW'(i * 4), 1, 0, 0, 0);
      idle(1);
      // random traffic
      do_reset();
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 3) == 0),
               ($urandom_range(0, 4) == 0),
               {$urandom, $urandom},
               ($urandom_range(0, 4) != 0),
               ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 3) == 0));
         if (i == 300) do_reset();
      end
      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
